pc_gen_btb: RTL and testbench

Parametrised fetch-stage program-counter generator for the RV32I 5-stage pipeline, with stall, execute-stage redirect and a direct-mapped branch target buffer (BTB) using 2-bit saturating counters. Each cycle it presents the fetch PC, a predicted-taken flag and the PC+4 value to the F stage. The E stage returns resolved control-transfer outcomes to train the BTB and correct mispredictions. It sits between the hazard unit (StallF, redirect) and instruction memory.

---
 rtl/pc_gen_btb.sv | 105 ++++++++++
 tb/tb_pc_gen_btb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_btb.sv
// Fetch-stage PC generator with a direct-mapped branch target buffer.
// Each BTB entry carries a 2-bit saturating counter; lookup is combinational on PCF.
module pc_gen_btb #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BTB_ENTRIES  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            RedirectE,
  input  logic [XLEN-1:0] RedirectPCE,
  input  logic            BrUpdE,
  input  logic [XLEN-1:0] BrPCE,
  input  logic            BrTakenE,
  input  logic [XLEN-1:0] BrTargetE,
  input  logic            FlushBTB,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic [XLEN-1:0]                  pc_reg, pc_next;
  logic [BTB_ENTRIES-1:0]           valid_reg, valid_next;
  logic [BTB_ENTRIES-1:0][1:0]      ctr_reg, ctr_next;
  logic [TAGW-1:0]                  tag_mem    [BTB_ENTRIES];
  logic [XLEN-1:0]                  target_mem [BTB_ENTRIES];

  // Lookup on the current fetch PC; sees pre-edge BTB contents only.
  logic [IDX-1:0]  lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            lk_hit;

  assign lk_idx      = pc_reg[IDX+1:2];
  assign lk_tag      = pc_reg[XLEN-1:IDX+2];
  assign lk_hit      = valid_reg[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign PredTakenF  = lk_hit && ctr_reg[lk_idx][1];
  assign PredTargetF = PredTakenF ? target_mem[lk_idx] : '0;
  assign PCF         = pc_reg;
  assign PCPlus4F    = pc_reg + XLEN'(4);

  // Training port from the execute stage.
  logic [IDX-1:0]  upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic            upd_hit;
  logic            upd_en;
  logic            wr_en;
  logic [1:0]      upd_ctr;
  logic [1:0]      ctr_inc;
  logic [1:0]      ctr_dec;

  assign upd_idx = BrPCE[IDX+1:2];
  assign upd_tag = BrPCE[XLEN-1:IDX+2];
  assign upd_hit = valid_reg[upd_idx] && (tag_mem[upd_idx] == upd_tag);
  assign upd_en  = BrUpdE && !FlushBTB;
  assign wr_en   = upd_en && BrTakenE && !rst;
  assign upd_ctr = ctr_reg[upd_idx];
  assign ctr_inc = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'b01;
  assign ctr_dec = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'b01;

  generate
    for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
      logic entry_sel;
      assign entry_sel = upd_en && (upd_idx == IDX'(gi));
      // A taken outcome always leaves the entry valid, whether it hit or allocated.
      assign valid_next[gi] = FlushBTB ? 1'b0 :
                              (entry_sel && BrTakenE) ? 1'b1 : valid_reg[gi];
      assign ctr_next[gi]   = !entry_sel ? ctr_reg[gi] :
                              upd_hit    ? (BrTakenE ? ctr_inc : ctr_dec) :
                              BrTakenE   ? 2'b10 : ctr_reg[gi];
    end
  endgenerate

  always_comb begin
    pc_next = PCPlus4F;
    if (RedirectE)       pc_next = RedirectPCE;
    else if (StallF)     pc_next = pc_reg;
    else if (PredTakenF) pc_next = PredTargetF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_VECTOR;
      valid_reg <= '0;
      ctr_reg   <= '0;
    end else begin
      pc_reg    <= pc_next;
      valid_reg <= valid_next;
      ctr_reg   <= ctr_next;
    end
  end

  // Tag and target need no reset: a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= BrTargetE;
    end
  end

endmodule

// File: tb/tb_pc_gen_btb.sv
// Self-checking bench for pc_gen_btb: per-scenario stimulus tables feed an
// expectation queue that is popped and compared one cycle after each drive.
module tb_pc_gen_btb;

  logic        clk = 1'b0;
  logic        rst, StallF, RedirectE, BrUpdE, BrTakenE, FlushBTB;
  logic [31:0] RedirectPCE, BrPCE, BrTargetE;
  logic [31:0] PCF, PCPlus4F, PredTargetF;
  logic        PredTakenF;

  pc_gen_btb #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0080),
    .BTB_ENTRIES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .StallF(StallF),
    .RedirectE(RedirectE),
    .RedirectPCE(RedirectPCE),
    .BrUpdE(BrUpdE),
    .BrPCE(BrPCE),
    .BrTakenE(BrTakenE),
    .BrTargetE(BrTargetE),
    .FlushBTB(FlushBTB),
    .PCF(PCF),
    .PCPlus4F(PCPlus4F),
    .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF)
  );

  always #5 clk = ~clk;

  // One row per cycle: inputs driven, then the outputs required after the edge.
  typedef struct packed {
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        upd;
    logic [31:0] bpc;
    logic        taken;
    logic [31:0] btgt;
    logic        flush;
    logic [31:0] epc;
    logic        ept;
    logic [31:0] etgt;
  } stim_t;

  typedef struct {
    string       name;
    logic [31:0] pcf;
    logic [31:0] pc4;
    logic        pt;
    logic [31:0] tgt;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input stim_t s, input string name);
    rst         = s.rst;
    StallF      = s.stall;
    RedirectE   = s.redir;
    RedirectPCE = s.rpc;
    BrUpdE      = s.upd;
    BrPCE       = s.bpc;
    BrTakenE    = s.taken;
    BrTargetE   = s.btgt;
    FlushBTB    = s.flush;
    exp_q.push_back('{name: name, pcf: s.epc, pc4: s.epc + 32'd4, pt: s.ept, tgt: s.etgt});
  endtask

  task automatic test_reset();
    stim_t tbl [4] = '{
      '{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0, 32'h80,1'b0,32'h0},
      '{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0, 32'h80,1'b0,32'h0},
      '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0, 32'h84,1'b0,32'h0},
      '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0, 32'h88,1'b0,32'h0}};
    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("reset[%0d]", i));
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({PCF, PCPlus4F, PredTakenF, PredTargetF} !== {e.pcf, e.pc4, e.pt, e.tgt}) begin
        n_fail++;
        $display("FAIL %s: got pcf=%h pc4=%h pt=%b tgt=%h, want pcf=%h pc4=%h pt=%b tgt=%h",
                 e.name, PCF, PCPlus4F, PredTakenF, PredTargetF, e.pcf, e.pc4, e.pt, e.tgt);
      end else
        $display("ok   %s: pcf=%h pt=%b tgt=%h", e.name, PCF, PredTakenF, PredTargetF);
    end
  endtask

  task automatic test_stall_redirect();
    stim_t tbl [6] = '{
      '{1'b0,1'b0,1'b1,32'h10, 1'b0,32'h0,1'b0,32'h0,1'b0, 32'h10, 1'b0,32'h0},
      '{1'b0,1'b1,1'b0,32'h0,  1'b0,32'h0,1'b0,32'h0,1'b0, 32'h10, 1'b0,32'h0},
      '{1'b0,1'b1,1'b0,32'h0,  1'b0,32'h0,1'b0,32'h0,1'b0, 32'h10, 1'b0,32'h0},
      '{1'b0,1'b1,1'b0,32'h0,  1'b0,32'h0,1'b0,32'h0,1'b0, 32'h10, 1'b0,32'h0},
      '{1'b0,1'b1,1'b1,32'h200,1'b0,32'h0,1'b0,32'h0,1'b0, 32'h200,1'b0,32'h0},
      '{1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0,1'b0,32'h0,1'b0, 32'h204,1'b0,32'h0}};
    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("stall_redirect[%0d]", i));
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({PCF, PCPlus4F, PredTakenF, PredTargetF} !== {e.pcf, e.pc4, e.pt, e.tgt}) begin
        n_fail++;
        $display("FAIL %s: got pcf=%h pc4=%h pt=%b tgt=%h, want pcf=%h pc4=%h pt=%b tgt=%h",
                 e.name, PCF, PCPlus4F, PredTakenF, PredTargetF, e.pcf, e.pc4, e.pt, e.tgt);
      end else
        $display("ok   %s: pcf=%h pt=%b tgt=%h", e.name, PCF, PredTakenF, PredTargetF);
    end
  endtask

  task automatic test_btb_alloc();
    stim_t tbl [6] = '{
      '{1'b0,1'b0,1'b1,32'h30,1'b1,32'h40,1'b1,32'h100,1'b0, 32'h30, 1'b0,32'h0},
      '{1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0,  1'b0, 32'h34, 1'b0,32'h0},
      '{1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0,  1'b0, 32'h38, 1'b0,32'h0},
      '{1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0,  1'b0, 32'h3C, 1'b0,32'h0},
      '{1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0,  1'b0, 32'h40, 1'b1,32'h100},
      '{1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0,  1'b0, 32'h100,1'b0,32'h0}};
    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("btb_alloc[%0d]", i));
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({PCF, PCPlus4F, PredTakenF, PredTargetF} !== {e.pcf, e.pc4, e.pt, e.tgt}) begin
        n_fail++;
        $display("FAIL %s: got pcf=%h pc4=%h pt=%b tgt=%h, want pcf=%h pc4=%h pt=%b tgt=%h",
                 e.name, PCF, PCPlus4F, PredTakenF, PredTargetF, e.pcf, e.pc4, e.pt, e.tgt);
      end else
        $display("ok   %s: pcf=%h pt=%b tgt=%h", e.name, PCF, PredTakenF, PredTargetF);
    end
  endtask

  // Counter walk at 0x40 while fetch is stalled there: 2,1,0,0,1,2,3,3,2,1.
  task automatic test_hysteresis();
    stim_t tbl [10] = '{
      '{1'b0,1'b0,1'b1,32'h40,1'b1,32'h40,1'b0,32'h0,  1'b0, 32'h40,1'b0,32'h0},
      '{1'b0,1'b1,1'b0,32'h0, 1'b1,32'h40,1'b0,32'h0,  1'b0, 32'h40,1'b0,32'h0},
      '{1'b0,1'b1,1'b0,32'h0, 1'b1,32'h40,1'b0,32'h0,  1'b0, 32'h40,1'b0,32'h0},
      '{1'b0,1'b1,1'b0,32'h0, 1'b1,32'h40,1'b1,32'h100,1'b0, 32'h40,1'b0,32'h0},
      '{1'b0,1'b1,1'b0,32'h0, 1'b1,32'h40,1'b1,32'h100,1'b0, 32'h40,1'b1,32'h100},
      '{1'b0,1'b1,1'b0,32'h0, 1'b1,32'h40,1'b1,32'h100,1'b0, 32'h40,1'b1,32'h100},
      '{1'b0,1'b1,1'b0,32'h0, 1'b1,32'h40,1'b1,32'h104,1'b0, 32'h40,1'b1,32'h104},
      '{1'b0,1'b1,1'b0,32'h0, 1'b1,32'h40,1'b0,32'h999,1'b0, 32'h40,1'b1,32'h104},
      '{1'b0,1'b1,1'b0,32'h0, 1'b1,32'h40,1'b0,32'h0,  1'b0, 32'h40,1'b0,32'h0},
      '{1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0,  1'b0, 32'h44,1'b0,32'h0}};
    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("hysteresis[%0d]", i));
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({PCF, PCPlus4F, PredTakenF, PredTargetF} !== {e.pcf, e.pc4, e.pt, e.tgt}) begin
        n_fail++;
        $display("FAIL %s: got pcf=%h pc4=%h pt=%b tgt=%h, want pcf=%h pc4=%h pt=%b tgt=%h",
                 e.name, PCF, PCPlus4F, PredTakenF, PredTargetF, e.pcf, e.pc4, e.pt, e.tgt);
      end else
        $display("ok   %s: pcf=%h pt=%b tgt=%h", e.name, PCF, PredTakenF, PredTargetF);
    end
  endtask

  // 0x80 shares index 0 with 0x40; then a flush that also drops a coincident update.
  task automatic test_alias_flush();
    stim_t tbl [6] = '{
      '{1'b0,1'b0,1'b1,32'h40,1'b1,32'h80,1'b1,32'h300,1'b0, 32'h40, 1'b0,32'h0},
      '{1'b0,1'b0,1'b1,32'h80,1'b0,32'h0, 1'b0,32'h0,  1'b0, 32'h80, 1'b1,32'h300},
      '{1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0,  1'b0, 32'h300,1'b0,32'h0},
      '{1'b0,1'b0,1'b1,32'h80,1'b1,32'h20,1'b1,32'h500,1'b1, 32'h80, 1'b0,32'h0},
      '{1'b0,1'b0,1'b1,32'h20,1'b0,32'h0, 1'b0,32'h0,  1'b0, 32'h20, 1'b0,32'h0},
      '{1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0,  1'b0, 32'h24, 1'b0,32'h0}};
    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("alias_flush[%0d]", i));
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({PCF, PCPlus4F, PredTakenF, PredTargetF} !== {e.pcf, e.pc4, e.pt, e.tgt}) begin
        n_fail++;
        $display("FAIL %s: got pcf=%h pc4=%h pt=%b tgt=%h, want pcf=%h pc4=%h pt=%b tgt=%h",
                 e.name, PCF, PCPlus4F, PredTakenF, PredTargetF, e.pcf, e.pc4, e.pt, e.tgt);
      end else
        $display("ok   %s: pcf=%h pt=%b tgt=%h", e.name, PCF, PredTakenF, PredTargetF);
    end
  endtask

  // Two entries pointing at each other: fetch ping-pongs with zero bubbles.
  task automatic test_back_to_back();
    stim_t tbl [5] = '{
      '{1'b0,1'b1,1'b0,32'h0,1'b1,32'h24,1'b1,32'h60,1'b0, 32'h24,1'b1,32'h60},
      '{1'b0,1'b1,1'b0,32'h0,1'b1,32'h60,1'b1,32'h24,1'b0, 32'h24,1'b1,32'h60},
      '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,32'h0, 1'b0, 32'h60,1'b1,32'h24},
      '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,32'h0, 1'b0, 32'h24,1'b1,32'h60},
      '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,32'h0, 1'b0, 32'h60,1'b1,32'h24}};
    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("back_to_back[%0d]", i));
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({PCF, PCPlus4F, PredTakenF, PredTargetF} !== {e.pcf, e.pc4, e.pt, e.tgt}) begin
        n_fail++;
        $display("FAIL %s: got pcf=%h pc4=%h pt=%b tgt=%h, want pcf=%h pc4=%h pt=%b tgt=%h",
                 e.name, PCF, PCPlus4F, PredTakenF, PredTargetF, e.pcf, e.pc4, e.pt, e.tgt);
      end else
        $display("ok   %s: pcf=%h pt=%b tgt=%h", e.name, PCF, PredTakenF, PredTargetF);
    end
  endtask

  // PC wrap at the top of the address space, then reset during stall+redirect.
  task automatic test_wrap_reset();
    stim_t tbl [7] = '{
      '{1'b0,1'b0,1'b1,32'hFFFF_FFFC,1'b0,32'h0, 1'b0,32'h0,  1'b0, 32'hFFFF_FFFC,1'b0,32'h0},
      '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0, 1'b0,32'h0,  1'b0, 32'h0,        1'b0,32'h0},
      '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0, 1'b0,32'h0,  1'b0, 32'h4,        1'b0,32'h0},
      '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h84,1'b1,32'h400,1'b0, 32'h4,        1'b0,32'h0},
      '{1'b1,1'b1,1'b1,32'h200,      1'b0,32'h0, 1'b0,32'h0,  1'b0, 32'h80,       1'b0,32'h0},
      '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0, 1'b0,32'h0,  1'b0, 32'h84,       1'b0,32'h0},
      '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0, 1'b0,32'h0,  1'b0, 32'h88,       1'b0,32'h0}};
    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("wrap_reset[%0d]", i));
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({PCF, PCPlus4F, PredTakenF, PredTargetF} !== {e.pcf, e.pc4, e.pt, e.tgt}) begin
        n_fail++;
        $display("FAIL %s: got pcf=%h pc4=%h pt=%b tgt=%h, want pcf=%h pc4=%h pt=%b tgt=%h",
                 e.name, PCF, PCPlus4F, PredTakenF, PredTargetF, e.pcf, e.pc4, e.pt, e.tgt);
      end else
        $display("ok   %s: pcf=%h pt=%b tgt=%h", e.name, PCF, PredTakenF, PredTargetF);
    end
  endtask

  initial begin
    rst = 1'b1; StallF = 1'b0; RedirectE = 1'b0; RedirectPCE = '0;
    BrUpdE = 1'b0; BrPCE = '0; BrTakenE = 1'b0; BrTargetE = '0; FlushBTB = 1'b0;
    test_reset();
    test_stall_redirect();
    test_btb_alloc();
    test_hysteresis();
    test_alias_flush();
    test_back_to_back();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
